// File: rtl/bp_fe_bp_gshare_spec.sv
// Gshare branch direction predictor with speculative global history,
// per-prediction history checkpoints, redirect restore and a post-reset init sweep.
module bp_fe_bp_gshare_spec #(
    parameter int bht_idx_width_p   = 10,
    parameter int ghist_width_p     = 8,
    parameter int bp_cnt_sat_bits_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       init_done_o,

    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    output logic [ghist_width_p-1:0]   ghist_o,

    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic [ghist_width_p-1:0]   ghist_w_i,
    input  logic                       taken_i,

    input  logic                       redirect_v_i,
    input  logic [ghist_width_p-1:0]   redirect_ghist_i,
    input  logic                       redirect_taken_i
);

    localparam int I = bht_idx_width_p;
    localparam int G = ghist_width_p;
    localparam int N = bp_cnt_sat_bits_p;
    localparam int els_lp = 1 << I;
    localparam logic [N-1:0] cnt_init_lp = N'((1 << (N - 1)) - 1);
    localparam logic [N-1:0] cnt_max_lp  = '1;

    typedef enum logic {
        e_init,
        e_run
    } state_e;

    state_e         state_r, state_n;
    logic [I-1:0]   init_cnt_r;
    logic [G-1:0]   ghist_r, ghist_n;
    logic [N-1:0]   mem_r [els_lp];

    logic           run;
    logic [I-1:0]   idx_r_hash, idx_w_hash;
    logic [N-1:0]   w_cnt, w_cnt_n, r_cnt;
    logic           pred;
    logic           unused_redirect_msb;

    assign run                 = (state_r == e_run);
    assign init_done_o         = run;
    assign unused_redirect_msb = redirect_ghist_i[G-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= e_init;
            init_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == e_init) begin
                init_cnt_r <= init_cnt_r + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        if (state_r == e_init && init_cnt_r == '1) begin
            state_n = e_run;
        end
    end

    // History is zero-extended on the MSB side before hashing.
    assign idx_r_hash = idx_r_i ^ I'(ghist_r);
    assign idx_w_hash = idx_w_i ^ I'(ghist_w_i);

    assign w_cnt = mem_r[idx_w_hash];

    always_comb begin
        w_cnt_n = w_cnt;
        if (taken_i) begin
            if (w_cnt != cnt_max_lp) begin
                w_cnt_n = w_cnt + 1'b1;
            end
        end else begin
            if (w_cnt != '0) begin
                w_cnt_n = w_cnt - 1'b1;
            end
        end
    end

    // Write-first bypass so a same-cycle update is visible to the read.
    always_comb begin
        r_cnt = mem_r[idx_r_hash];
        if (w_v_i && idx_w_hash == idx_r_hash) begin
            r_cnt = w_cnt_n;
        end
    end

    assign pred = r_cnt[N-1];

    always_ff @(posedge clk_i) begin
        if (!run) begin
            mem_r[init_cnt_r] <= cnt_init_lp;
        end else if (w_v_i) begin
            mem_r[idx_w_hash] <= w_cnt_n;
        end
    end

    // Redirect restore takes priority over the speculative shift.
    always_comb begin
        ghist_n = ghist_r;
        if (run) begin
            if (redirect_v_i) begin
                ghist_n = {redirect_ghist_i[G-2:0], redirect_taken_i};
            end else if (r_v_i) begin
                ghist_n = {ghist_r[G-2:0], pred};
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ghist_r     <= '0;
            predict_v_o <= 1'b0;
            predict_o   <= 1'b0;
            ghist_o     <= '0;
        end else begin
            ghist_r     <= ghist_n;
            predict_v_o <= run & r_v_i;
            if (run && r_v_i) begin
                predict_o <= pred;
                ghist_o   <= ghist_r;
            end
        end
    end

endmodule

// File: tb/tb_bp_fe_bp_gshare_spec.sv
// Directed table-driven bench for the gshare predictor.
module tb_bp_fe_bp_gshare_spec;

    localparam int I = 10;
    localparam int G = 8;
    localparam int N = 2;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         init_done_o;
    logic         r_v_i = 1'b0;
    logic [I-1:0] idx_r_i = '0;
    logic         predict_v_o;
    logic         predict_o;
    logic [G-1:0] ghist_o;
    logic         w_v_i = 1'b0;
    logic [I-1:0] idx_w_i = '0;
    logic [G-1:0] ghist_w_i = '0;
    logic         taken_i = 1'b0;
    logic         redirect_v_i = 1'b0;
    logic [G-1:0] redirect_ghist_i = '0;
    logic         redirect_taken_i = 1'b0;

    bp_fe_bp_gshare_spec #(
        .bht_idx_width_p(I),
        .ghist_width_p(G),
        .bp_cnt_sat_bits_p(N)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .init_done_o(init_done_o),
        .r_v_i(r_v_i),
        .idx_r_i(idx_r_i),
        .predict_v_o(predict_v_o),
        .predict_o(predict_o),
        .ghist_o(ghist_o),
        .w_v_i(w_v_i),
        .idx_w_i(idx_w_i),
        .ghist_w_i(ghist_w_i),
        .taken_i(taken_i),
        .redirect_v_i(redirect_v_i),
        .redirect_ghist_i(redirect_ghist_i),
        .redirect_taken_i(redirect_taken_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         r_v;
        logic [I-1:0] idx_r;
        logic         w_v;
        logic [I-1:0] idx_w;
        logic [G-1:0] ghist_w;
        logic         taken;
        logic         rd_v;
        logic [G-1:0] rd_g;
        logic         rd_t;
        logic         pv;
        logic         pred;
        logic [G-1:0] gh;
        string        nm;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(
        input logic r_v, input logic [I-1:0] idx_r,
        input logic w_v, input logic [I-1:0] idx_w,
        input logic [G-1:0] ghist_w, input logic taken,
        input logic rd_v, input logic [G-1:0] rd_g, input logic rd_t,
        input logic pv, input logic pred, input logic [G-1:0] gh,
        input string nm);
        vec_t v;
        v.r_v = r_v; v.idx_r = idx_r; v.w_v = w_v; v.idx_w = idx_w;
        v.ghist_w = ghist_w; v.taken = taken;
        v.rd_v = rd_v; v.rd_g = rd_g; v.rd_t = rd_t;
        v.pv = pv; v.pred = pred; v.gh = gh; v.nm = nm;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        r_v_i = 1'b0; idx_r_i = '0;
        w_v_i = 1'b0; idx_w_i = '0; ghist_w_i = '0; taken_i = 1'b0;
        redirect_v_i = 1'b0; redirect_ghist_i = '0; redirect_taken_i = 1'b0;
    endtask

    initial begin
        //   r idx_r    w idx_w    ghw   tk rd rd_g  rt pv pr gh
        add(1, 10'h005, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, "first_pred");
        add(0, 10'h000, 1, 10'h00A, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, "upd_a_1");
        add(0, 10'h000, 1, 10'h00A, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, "upd_a_2");
        add(0, 10'h000, 1, 10'h00A, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, "upd_a_sat1");
        add(0, 10'h000, 1, 10'h00A, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, "upd_a_sat2");
        add(0, 10'h000, 1, 10'h00A, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, "upd_a_nt");
        add(0, 10'h000, 1, 10'h008, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, "upd_8_1");
        add(0, 10'h000, 1, 10'h008, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, "upd_8_2");
        add(1, 10'h00A, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h00, "pred_a_g00");
        add(1, 10'h00A, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h01, "pred_a_g01");
        add(1, 10'h00A, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h02, "pred_a_g02");
        add(1, 10'h00D, 0, 10'h000, 8'h00, 0, 1, 8'h81, 1, 1, 1, 8'h05, "redir_pred");
        add(1, 10'h000, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h03, "post_redir");
        add(1, 10'h020, 1, 10'h026, 8'h00, 1, 0, 8'h00, 0, 1, 1, 8'h06, "bypass");
        add(1, 10'h02B, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'h0D, "bypass_wr");
        add(0, 10'h000, 1, 10'h100, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h0D, "dec_100");
        add(0, 10'h000, 1, 10'h155, 8'h55, 0, 0, 8'h00, 0, 0, 1, 8'h0D, "dec_sat0");
        add(1, 10'h11B, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h1B, "pred_100");
        add(0, 10'h000, 0, 10'h000, 8'h00, 0, 1, 8'hF0, 0, 0, 0, 8'h1B, "redir_only");
        add(1, 10'h0E0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'hE0, "pred_gE0");
        add(1, 10'h0CA, 0, 10'h000, 8'h00, 0, 0, 8'h00, 0, 1, 1, 8'hC0, "pred_gC0");

        tick();
        tick();
        check("rst_done", 32'(init_done_o), 32'(1'b0));
        check("rst_pv", 32'(predict_v_o), 32'(1'b0));
        check("rst_pred", 32'(predict_o), 32'(1'b0));
        check("rst_ghist", 32'(ghist_o), 32'(8'h00));

        r_v_i = 1'b1;
        idx_r_i = 10'h005;
        w_v_i = 1'b1;
        redirect_v_i = 1'b1;
        reset_i = 1'b0;
        repeat (1023) tick();
        check("init_pv", 32'(predict_v_o), 32'(1'b0));
        check("init_not_done", 32'(init_done_o), 32'(1'b0));
        tick();
        check("init_done", 32'(init_done_o), 32'(1'b1));
        check("init_pv_last", 32'(predict_v_o), 32'(1'b0));
        idle_inputs();

        for (int i = 0; i < vecs.size(); i++) begin
            r_v_i = vecs[i].r_v;
            idx_r_i = vecs[i].idx_r;
            w_v_i = vecs[i].w_v;
            idx_w_i = vecs[i].idx_w;
            ghist_w_i = vecs[i].ghist_w;
            taken_i = vecs[i].taken;
            redirect_v_i = vecs[i].rd_v;
            redirect_ghist_i = vecs[i].rd_g;
            redirect_taken_i = vecs[i].rd_t;
            tick();
            check({vecs[i].nm, "_pv"}, 32'(predict_v_o), 32'(vecs[i].pv));
            check({vecs[i].nm, "_pred"}, 32'(predict_o), 32'(vecs[i].pred));
            check({vecs[i].nm, "_gh"}, 32'(ghist_o), 32'(vecs[i].gh));
        end
        idle_inputs();

        reset_i = 1'b1;
        #1;
        check("midrst_done", 32'(init_done_o), 32'(1'b0));
        check("midrst_pv", 32'(predict_v_o), 32'(1'b0));
        check("midrst_pred", 32'(predict_o), 32'(1'b0));
        check("midrst_ghist", 32'(ghist_o), 32'(8'h00));
        tick();
        reset_i = 1'b0;
        cyc = 0;
        while (!init_done_o && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("reinit_cycles", 32'(cyc), 32'(1024));

        r_v_i = 1'b1;
        idx_r_i = 10'h008;
        tick();
        idle_inputs();
        check("reinit_pv", 32'(predict_v_o), 32'(1'b1));
        check("reinit_pred", 32'(predict_o), 32'(1'b0));
        check("reinit_gh", 32'(ghist_o), 32'(8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_fe_bp_gshare_spec.md
Name: bp_fe_bp_gshare_spec

Overview:
- Parametrised gshare branch direction predictor for the front end, successor to the basic gshare BHT.
- Adds a configurable global-history length independent of table depth, and speculative history update at predict time.
- Exports a history checkpoint with every prediction and supports history restore on redirect.
- Updates use actual outcome plus the predict-time checkpoint.
- Table is cleared after reset by a sequential init sweep, not a flop reset.

Parameters:
- bht_idx_width_p, 10, log2 of BHT entries (els = 2**bht_idx_width_p).
- ghist_width_p, 8, global history bits. Legal range 2..bht_idx_width_p. Zero-extended on the MSB side before hashing.
- bp_cnt_sat_bits_p, 2, saturating counter width. Init value is weakly-not-taken, 2**(N-1)-1.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- init_done_o  out  1  high once the init sweep has finished (RUN state).
- r_v_i  in  1  prediction request valid.
- idx_r_i  in  bht_idx_width_p  PC-derived prediction index.
- predict_v_o  out  1  prediction valid, one cycle after an accepted r_v_i.
- predict_o  out  1  1 = taken.
- ghist_o  out  ghist_width_p  history used for this prediction (checkpoint).
- w_v_i  in  1  training update valid.
- idx_w_i  in  bht_idx_width_p  PC-derived index of the resolved branch.
- ghist_w_i  in  ghist_width_p  checkpoint returned with that branch's prediction.
- taken_i  in  1  actual resolved direction.
- redirect_v_i  in  1  history restore valid.
- redirect_ghist_i  in  ghist_width_p  checkpoint of the redirecting branch.
- redirect_taken_i  in  1  actual direction of the redirecting branch.

Behaviour:
- Reset (async assert):
  - State goes to INIT, init counter = 0, ghist = 0.
  - init_done_o, predict_v_o, predict_o and ghist_o all = 0 immediately.
- INIT state:
  - Writes one entry per cycle, entry[cnt] <= 2**(N-1)-1, cnt++.
  - After writing entry els-1, moves to RUN. init_done_o = 1 in the following cycle, exactly els cycles after reset deassert.
  - r_v_i, w_v_i and redirect_v_i are ignored; predict_v_o stays 0.
- Index hash: idx = idx_i XOR {zeros, ghist}, computed for both the read and write ports.
- Predict (RUN, r_v_i):
  - Read idx_r = idx_r_i ^ ghist. pred = counter > 2**(N-1)-1 (counter MSB).
  - Next cycle: predict_v_o = 1, predict_o = pred, ghist_o = ghist value before the shift.
  - Same edge: ghist <= {ghist[G-2:0], pred} (speculative shift).
  - Without r_v_i: predict_v_o = 0 next cycle; predict_o and ghist_o hold their last values.
- Update (RUN, w_v_i):
  - idx_w = idx_w_i ^ ghist_w_i.
  - taken_i = 1: increment, saturating at 2**N-1. taken_i = 0: decrement, saturating at 0.
  - Does not modify ghist.
- Redirect (RUN, redirect_v_i): ghist <= {redirect_ghist_i[G-2:0], redirect_taken_i}.
- Simultaneous events:
  - redirect_v_i with r_v_i: the prediction is still produced from the pre-redirect ghist, but redirect wins the ghist write and the speculative bit is dropped.
  - w_v_i and r_v_i to the same hashed index: write-first bypass, so the prediction uses the post-update counter value.
  - Updates to different indices are independent.
- Reset during RUN or INIT: async clear as above, then a full INIT sweep again. All trained state is lost.
- No backpressure: one request and one update may be accepted per cycle.

Test Plan (defaults: 1024 entries, G=8, N=2):
- Reset, deassert → init_done_o rises exactly 1024 cycles later. r_v_i during INIT gives predict_v_o = 0. First predict idx 0x005 → predict_v_o=1, predict_o=0, ghist_o=0x00.
- Two updates at idx 0x00A, ghist_w 0x00, taken=1 → counter 1→2→3. Two more taken stay at 3. One not-taken → 2. Predict at 0x00A with ghist=0 → 1.
- After a taken prediction, the next ghist_o = 0x01. Then a not-taken prediction → the following ghist_o = 0x02. Verify index 0x00A^0x02 = 0x008 is the entry read.
- redirect_v_i with ghist 0x81, taken=1, in the same cycle as a taken r_v_i → that prediction's ghist_o = pre-redirect value. Next ghist_o = 0x03.
- Same-cycle w_v_i taken and r_v_i on a hashed index holding counter 1 → predict_o = 1 (bypassed value 2).
- Assert reset mid-RUN after training → outputs 0 within the same cycle. After re-init, predict at the previously saturated index → 0.
